// File: rtl/mac_pkg.sv
// Shared definitions for the sequential binary MAC.
//   mac_state_t : controller states (IDLE, MUL, DONE)
//   acc_width() : accumulator width that holds SETS*MAX_BEATS products
//                 of two SIZE-bit operands without overflow.
package mac_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        MUL  = 2'd1,
        DONE = 2'd2
    } mac_state_t;

    function automatic int acc_width(input int size, input int sets, input int max_beats);
        return 2 * size + $clog2(sets * max_beats);
    endfunction

endpackage

// File: rtl/mac_product.sv
// Combinational SIZE x SIZE multiplier shared by all sets of a beat.
// Ports:
//   i_a, i_b : SIZE-bit operands (two's complement when SIGNED != 0)
//   o_p      : 2*SIZE-bit product (exact; never truncated)
module mac_product #(
    parameter int SIZE   = 4,
    parameter int SIGNED = 0
) (
    input  logic [SIZE-1:0]   i_a,
    input  logic [SIZE-1:0]   i_b,
    output logic [2*SIZE-1:0] o_p
);

    logic [2*SIZE-1:0] w_a_ext;
    logic [2*SIZE-1:0] w_b_ext;

    // Extending both operands to the product width first makes the
    // low 2*SIZE bits of the product exact for both signednesses.
    generate
        if (SIGNED != 0) begin : g_signed
            assign w_a_ext = {{SIZE{i_a[SIZE-1]}}, i_a};
            assign w_b_ext = {{SIZE{i_b[SIZE-1]}}, i_b};
        end else begin : g_unsigned
            assign w_a_ext = {{SIZE{1'b0}}, i_a};
            assign w_b_ext = {{SIZE{1'b0}}, i_b};
        end
    endgenerate

    assign o_p = w_a_ext * w_b_ext;

endmodule

// File: rtl/seq_binary_mac.sv
// Sequential dot-product unit. Each accepted beat carries SETS operand
// pairs which are multiplied one per cycle (set 0 first) through a single
// mac_product and summed into an accumulator. Beats accumulate until one
// flagged in_last, after which the sum is offered on a valid/ready port.
// Ports:
//   clock, reset          : rising-edge clock, synchronous active-high reset
//   in_valid/in_ready     : input beat handshake; in_last marks final beat
//   a, b                  : packed operands, set i at [i*SIZE +: SIZE]
//   out_valid/out_ready   : result handshake
//   out                   : accumulated dot product (wraps mod 2^ACC_W)
//   overflow              : more than MAX_BEATS beats went into this result
module seq_binary_mac
    import mac_pkg::*;
#(
    parameter int SIZE      = 4,
    parameter int SETS      = 4,
    parameter int MAX_BEATS = 4,
    parameter int SIGNED    = 0,
    parameter int ACC_W     = acc_width(SIZE, SETS, MAX_BEATS)
) (
    input  logic                 clock,
    input  logic                 reset,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic                 in_last,
    input  logic [SETS*SIZE-1:0] a,
    input  logic [SETS*SIZE-1:0] b,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [ACC_W-1:0]     out,
    output logic                 overflow
);

    localparam int PROD_W = 2 * SIZE;
    localparam int IDX_W  = (SETS > 1) ? $clog2(SETS) : 1;
    localparam int CNT_W  = $clog2(MAX_BEATS + 1);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(SETS - 1);
    localparam logic [CNT_W-1:0] MAX_CNT  = CNT_W'(MAX_BEATS);

    mac_state_t             r_state;
    mac_state_t             w_next_state;
    logic [SETS*SIZE-1:0]   r_a;
    logic [SETS*SIZE-1:0]   r_b;
    logic                   r_last;
    logic [IDX_W-1:0]       r_idx;
    logic [CNT_W-1:0]       r_beats;
    logic                   r_ovf;
    logic [ACC_W-1:0]       r_acc;

    logic [SIZE-1:0]        w_a_set [SETS];
    logic [SIZE-1:0]        w_b_set [SETS];
    logic [PROD_W-1:0]      w_prod;
    logic [ACC_W-1:0]       w_prod_ext;
    logic                   w_accept;

    // Unpack the registered beat into per-set operand arrays.
    genvar gi;
    generate
        for (gi = 0; gi < SETS; gi++) begin : g_sets
            assign w_a_set[gi] = r_a[gi*SIZE +: SIZE];
            assign w_b_set[gi] = r_b[gi*SIZE +: SIZE];
        end
    endgenerate

    mac_product #(
        .SIZE   (SIZE),
        .SIGNED (SIGNED)
    ) u_product (
        .i_a (w_a_set[r_idx]),
        .i_b (w_b_set[r_idx]),
        .o_p (w_prod)
    );

    generate
        if (SIGNED != 0) begin : g_ext_signed
            assign w_prod_ext = ACC_W'($signed(w_prod));
        end else begin : g_ext_unsigned
            assign w_prod_ext = ACC_W'(w_prod);
        end
    endgenerate

    // Handshake outputs are forced low while reset is asserted so that no
    // transfer can be seen on the reset cycle itself.
    always_comb begin
        w_next_state = r_state;
        in_ready     = 1'b0;
        out_valid    = 1'b0;
        case (r_state)
            IDLE: begin
                in_ready = !reset;
                if (in_valid) begin
                    w_next_state = MUL;
                end
            end
            MUL: begin
                if (r_idx == LAST_IDX) begin
                    w_next_state = r_last ? DONE : IDLE;
                end
            end
            DONE: begin
                out_valid = !reset;
                if (out_ready) begin
                    w_next_state = IDLE;
                end
            end
            default: w_next_state = IDLE;
        endcase
    end

    assign w_accept = in_valid && in_ready;
    assign out      = out_valid ? r_acc : '0;
    assign overflow = out_valid && r_ovf;

    always_ff @(posedge clock) begin
        if (reset) begin
            r_state <= IDLE;
            r_a     <= '0;
            r_b     <= '0;
            r_last  <= 1'b0;
            r_idx   <= '0;
            r_beats <= '0;
            r_ovf   <= 1'b0;
            r_acc   <= '0;
        end else begin
            r_state <= w_next_state;
            case (r_state)
                IDLE: begin
                    if (w_accept) begin
                        r_a    <= a;
                        r_b    <= b;
                        r_last <= in_last;
                        r_idx  <= '0;
                        // Count saturates; any beat beyond the limit only
                        // raises the sticky flag.
                        if (r_beats == MAX_CNT) begin
                            r_ovf <= 1'b1;
                        end else begin
                            r_beats <= r_beats + 1'b1;
                        end
                    end
                end
                MUL: begin
                    r_acc <= r_acc + w_prod_ext;
                    r_idx <= (r_idx == LAST_IDX) ? '0 : r_idx + 1'b1;
                end
                DONE: begin
                    if (out_ready) begin
                        r_acc   <= '0;
                        r_beats <= '0;
                        r_ovf   <= 1'b0;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_seq_binary_mac.sv
// Directed bench for seq_binary_mac. Three instances share one stimulus
// stream: unsigned (MAX_BEATS=4), signed (MAX_BEATS=4) and unsigned with
// MAX_BEATS=2. All three have identical timing, so the shared handshake is
// driven from the unsigned instance and each result is checked per instance.
module tb_seq_binary_mac;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic        in_valid = 1'b0;
    logic        in_last = 1'b0;
    logic [15:0] a = '0;
    logic [15:0] b = '0;
    logic        out_ready = 1'b0;

    logic        rdy_u, rdy_s, rdy_o;
    logic        ov_u, ov_s, ov_o;
    logic [11:0] out_u, out_s;
    logic [10:0] out_o;
    logic        ovf_u, ovf_s, ovf_o;

    int total = 0;
    int bad = 0;
    logic saw_valid;
    logic saw_ready;
    int cyc;

    always #5 clock = ~clock;

    seq_binary_mac #(.SIZE(4), .SETS(4), .MAX_BEATS(4), .SIGNED(0)) u_dut_u (
        .clock(clock), .reset(reset), .in_valid(in_valid), .in_ready(rdy_u),
        .in_last(in_last), .a(a), .b(b), .out_valid(ov_u), .out_ready(out_ready),
        .out(out_u), .overflow(ovf_u)
    );

    seq_binary_mac #(.SIZE(4), .SETS(4), .MAX_BEATS(4), .SIGNED(1)) u_dut_s (
        .clock(clock), .reset(reset), .in_valid(in_valid), .in_ready(rdy_s),
        .in_last(in_last), .a(a), .b(b), .out_valid(ov_s), .out_ready(out_ready),
        .out(out_s), .overflow(ovf_s)
    );

    seq_binary_mac #(.SIZE(4), .SETS(4), .MAX_BEATS(2), .SIGNED(0)) u_dut_o (
        .clock(clock), .reset(reset), .in_valid(in_valid), .in_ready(rdy_o),
        .in_last(in_last), .a(a), .b(b), .out_valid(ov_o), .out_ready(out_ready),
        .out(out_o), .overflow(ovf_o)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%0d expected=%0d", tag, got, exp);
        end else begin
            $display("ok   %s: %0d", tag, got);
        end
    endtask

    // Presents a beat and returns on the falling edge after it is accepted
    // (first MUL cycle). Records any out_valid seen while waiting.
    task automatic send_beat(input logic [15:0] av, input logic [15:0] bv, input logic last);
        int n;
        n = 0;
        @(negedge clock);
        a = av;
        b = bv;
        in_last = last;
        in_valid = 1'b1;
        while (!(rdy_u && rdy_s && rdy_o) && n < 50) begin
            if (ov_u || ov_s || ov_o) saw_valid = 1'b1;
            @(negedge clock);
            n++;
        end
        if (n >= 50) chk("send_ready", {31'd0, rdy_u}, 32'd1);
        @(posedge clock);
        @(negedge clock);
        in_valid = 1'b0;
    endtask

    // Counts cycles from acceptance (cycle 1 = first MUL) until out_valid.
    task automatic wait_result(output int cycles);
        cycles = 1;
        saw_ready = 1'b0;
        while (!ov_u && cycles < 40) begin
            if (rdy_u) saw_ready = 1'b1;
            @(negedge clock);
            cycles++;
        end
        chk("valid_seen", {31'd0, ov_u}, 32'd1);
    endtask

    task automatic take_result(input string tag,
                               input logic [11:0] eu, input logic [11:0] es, input logic [10:0] eo,
                               input logic fu, input logic fs, input logic fo);
        chk({tag, "_out_u"}, {20'd0, out_u}, {20'd0, eu});
        chk({tag, "_out_s"}, {20'd0, out_s}, {20'd0, es});
        chk({tag, "_out_o"}, {21'd0, out_o}, {21'd0, eo});
        chk({tag, "_ovf_u"}, {31'd0, ovf_u}, {31'd0, fu});
        chk({tag, "_ovf_s"}, {31'd0, ovf_s}, {31'd0, fs});
        chk({tag, "_ovf_o"}, {31'd0, ovf_o}, {31'd0, fo});
        chk({tag, "_rdy_in_done"}, {31'd0, rdy_u}, 32'd0);
        out_ready = 1'b1;
        @(posedge clock);
        @(negedge clock);
        out_ready = 1'b0;
        chk({tag, "_valid_after"}, {29'd0, ov_u, ov_s, ov_o}, 32'd0);
        chk({tag, "_rdy_after"}, {29'd0, rdy_u, rdy_s, rdy_o}, 32'd7);
    endtask

    initial begin
        saw_valid = 1'b0;
        saw_ready = 1'b0;

        // Reset state
        repeat (2) @(negedge clock);
        chk("rst_in_ready", {29'd0, rdy_u, rdy_s, rdy_o}, 32'd0);
        chk("rst_out_valid", {29'd0, ov_u, ov_s, ov_o}, 32'd0);
        chk("rst_out", {20'd0, out_u}, 32'd0);
        reset = 1'b0;
        @(negedge clock);
        chk("idle_in_ready", {29'd0, rdy_u, rdy_s, rdy_o}, 32'd7);

        // Single beat: 64+0+0+64 in every flavour ((-8)*(-8)=64 signed)
        send_beat(16'h8088, 16'h8808, 1'b1);
        wait_result(cyc);
        chk("t1_latency", cyc, 32'd5);
        chk("t1_rdy_during_mul", {31'd0, saw_ready}, 32'd0);
        take_result("t1", 12'd128, 12'd128, 11'd128, 1'b0, 1'b0, 1'b0);

        // Two beats: unsigned 4*225 + 4*2 = 908; signed 4*1 + 4*2 = 12
        saw_valid = 1'b0;
        send_beat(16'hFFFF, 16'hFFFF, 1'b0);
        send_beat(16'h1111, 16'h2222, 1'b1);
        chk("t2_no_valid_between", {31'd0, saw_valid}, 32'd0);
        wait_result(cyc);
        chk("t2_latency", cyc, 32'd5);
        take_result("t2", 12'd908, 12'd12, 11'd908, 1'b0, 1'b0, 1'b0);

        // Signed: sets (0,F,0,F)x1 -> unsigned 30, signed -2
        send_beat(16'hF0F0, 16'h1111, 1'b1);
        wait_result(cyc);
        take_result("t3", 12'd30, 12'hFFE, 11'd30, 1'b0, 1'b0, 1'b0);

        // Backpressure: hold the result 3 cycles with a competing beat offered
        send_beat(16'h8088, 16'h8808, 1'b1);
        wait_result(cyc);
        a = 16'hFFFF;
        b = 16'hFFFF;
        in_last = 1'b1;
        in_valid = 1'b1;
        for (int k = 0; k < 3; k++) begin
            chk("bp_valid", {31'd0, ov_u}, 32'd1);
            chk("bp_out", {20'd0, out_u}, 32'd128);
            chk("bp_ovf", {31'd0, ovf_u}, 32'd0);
            chk("bp_in_ready", {31'd0, rdy_u}, 32'd0);
            @(negedge clock);
        end
        in_valid = 1'b0;
        take_result("bp", 12'd128, 12'd128, 11'd128, 1'b0, 1'b0, 1'b0);
        send_beat(16'h1111, 16'h1111, 1'b1);
        wait_result(cyc);
        take_result("bp_clear", 12'd4, 12'd4, 11'd4, 1'b0, 1'b0, 1'b0);

        // Overflow: three beats exceed MAX_BEATS=2 on the third instance only
        send_beat(16'h1111, 16'h1111, 1'b0);
        send_beat(16'h1111, 16'h1111, 1'b0);
        send_beat(16'h1111, 16'h1111, 1'b1);
        wait_result(cyc);
        take_result("ovf", 12'd12, 12'd12, 11'd12, 1'b0, 1'b0, 1'b1);
        send_beat(16'h1111, 16'h1111, 1'b1);
        wait_result(cyc);
        take_result("ovf_next", 12'd4, 12'd4, 11'd4, 1'b0, 1'b0, 1'b0);

        // Reset on the second MUL cycle
        send_beat(16'hFFFF, 16'hFFFF, 1'b1);
        @(negedge clock);
        reset = 1'b1;
        @(negedge clock);
        chk("rmul_valid", {29'd0, ov_u, ov_s, ov_o}, 32'd0);
        chk("rmul_out", {20'd0, out_u}, 32'd0);
        reset = 1'b0;
        @(negedge clock);
        chk("rmul_in_ready", {29'd0, rdy_u, rdy_s, rdy_o}, 32'd7);
        send_beat(16'h8088, 16'h8808, 1'b1);
        wait_result(cyc);
        chk("rmul_latency", cyc, 32'd5);
        take_result("rmul", 12'd128, 12'd128, 11'd128, 1'b0, 1'b0, 1'b0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/seq_binary_mac.md
Name: seq_binary_mac

Overview:
- Sequential, handshaked successor to the combinational binary dot-product unit in conventional_MAC.
- Each accepted beat carries SETS packed operand pairs. The block multiplies one pair per cycle through a single shared multiplier and accumulates the products.
- Results accumulate across multiple beats until a beat flagged last. The block then presents one dot-product result with a valid/ready handshake.
- Sits between the operand streamer and the result collector.

Parameters:
- SIZE, 4, bit width of each operand element.
- SETS, 4, number of element pairs per input beat.
- MAX_BEATS, 4, maximum beats per dot product without overflow.
- SIGNED, 0, 0 means unsigned operands; 1 means two's-complement operands.
- ACC_W, 2*SIZE+$clog2(SETS*MAX_BEATS), accumulator and result width (derived; do not override).

Ports:
- clock  input  1  rising-edge clock.
- reset  input  1  synchronous, active-high reset.
- in_valid  input  1  input beat valid.
- in_ready  output  1  block can accept a beat.
- in_last  input  1  beat is the final one of the current dot product.
- a  input  SETS*SIZE  operand A; set i is a[i*SIZE +: SIZE].
- b  input  SETS*SIZE  operand B; same packing as a.
- out_valid  output  1  result valid.
- out_ready  input  1  consumer accepts the result.
- out  output  ACC_W  accumulated dot product.
- overflow  output  1  beat count exceeded MAX_BEATS; qualified by out_valid.

Behaviour:
- Reset (synchronous, active-high; aborts any operation mid-flight):
  - state = IDLE, acc = 0, idx = 0, beat count = 0, overflow flag = 0.
  - out_valid = 0, out = 0, in_ready = 0 during the reset cycle, then 1 in IDLE.
- FSM states: IDLE, MUL, DONE.
- IDLE:
  - in_ready = 1.
  - On in_valid && in_ready: register a, b and in_last; set idx = 0; increment beat count; go to MUL.
  - If beat count is already MAX_BEATS at acceptance, set sticky overflow. The count saturates.
- MUL:
  - in_ready = 0.
  - Each cycle: acc <= acc + ext(a_q[idx] * b_q[idx]); idx increments.
  - On the cycle idx == SETS-1: go to DONE if last_q, else go to IDLE.
- DONE:
  - out_valid = 1, out = acc, overflow = sticky flag; in_ready = 0.
  - On out_ready: clear acc, beat count and overflow; go to IDLE.
  - out and overflow stay stable while out_valid && !out_ready.
- Latency:
  - SETS cycles per beat.
  - out_valid rises on the cycle after the final MUL cycle of the last beat.
  - Throughput is one beat per SETS+1 cycles, because IDLE costs one cycle.
- Arithmetic:
  - Product width is 2*SIZE.
  - SIGNED=0: zero-extend operands and product to ACC_W.
  - SIGNED=1: sign-extend operands and product.
  - The accumulator wraps modulo 2^ACC_W; there is no saturation.
- Elements are processed in ascending set order, set 0 first.
- in_valid while in_ready = 0 is ignored; the producer must hold the beat.
- out_ready while out_valid = 0 is ignored.

Decomposition:
- Package mac_pkg:
  - state enum (IDLE, MUL, DONE).
  - function acc_width(SIZE, SETS, MAX_BEATS).
- Sub-module mac_product:
  - Combinational SIZE x SIZE multiplier.
  - SIGNED parameter; 2*SIZE-bit output.
  - Instantiated once and time-multiplexed across the sets.
- The FSM, index counter, beat counter and accumulator live in seq_binary_mac.

Test Plan:
- Single beat (SIZE=4, SETS=4): a=16'h8088, b=16'h8808, in_last=1 -> out=128 (set products 64+0+0+64), overflow=0. out_valid rises 5 cycles after acceptance; in_ready=0 during MUL and DONE.
- Two beats: beat 1 a=16'hFFFF, b=16'hFFFF, in_last=0; beat 2 a=16'h1111, b=16'h2222, in_last=1 -> single result out=908 (900+8). No out_valid between the beats.
- Signed (SIGNED=1): a=16'hF0F0, b=16'h1111, in_last=1 -> out=12'hFFE (-2).
- Backpressure: hold out_ready=0 for 3 cycles in DONE -> out, out_valid and overflow are stable and in_valid is ignored. Raise out_ready -> next cycle out_valid=0, in_ready=1, and a following beat of 16'h1111·16'h1111 yields 4, proving acc was cleared.
- Overflow (MAX_BEATS=2): three beats of 16'h1111·16'h1111, the last flagged -> out=12, overflow=1. The next dot product reports overflow=0.
- Reset mid-MUL: assert reset on the second MUL cycle -> next cycle out_valid=0, out=0, in_ready=1 after release. A fresh single beat 16'h8088·16'h8808 yields 128.
